// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the integer ALU issue path.
// This package holds the ALUOp codes, the base opcodes and the funct7 selectors.
package rv32_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of RV32I ALU-class instructions into ALU operands and ALUOp.
// Any unsupported encoding yields illegal=1 with a zeroed ADD so the trap path sees a clean entry.
module alu_decode
   import rv32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [31:0]      instr,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [3:0]       aluop,
   output logic [4:0]       rd,
   output logic             wb_en,
   output logic             illegal
);

   function automatic logic signed [WIDTH-1:0] sext_i(input logic [31:0] ins);
      return {{(WIDTH-12){ins[31]}}, ins[31:20]};
   endfunction

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic signed [WIDTH-1:0] imm_i;
   logic [WIDTH-1:0] imm_u;
   logic [WIDTH-1:0] shamt;
   logic             bad;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign rd    = instr[11:7];
   assign imm_i = sext_i(instr);
   assign imm_u = WIDTH'({instr[31:12], 12'b0});
   assign shamt = WIDTH'(instr[24:20]);

   always_comb begin
      a     = '0;
      b     = '0;
      aluop = ALU_ADD;
      bad   = 1'b0;
      case (opc)
         OPC_OP, OPC_OPIMM: begin
            a = rs1;
            b = (opc == OPC_OP) ? rs2 : imm_i;
            case (f3)
               3'b000: begin
                  // OP-IMM has no SUBI, so its funct7 bits are immediate and not checked
                  if (opc == OPC_OPIMM || f7 == F7_BASE) aluop = ALU_ADD;
                  else if (f7 == F7_ALT)                 aluop = ALU_SUB;
                  else                                   bad   = 1'b1;
               end
               3'b001: begin
                  aluop = ALU_SLL;
                  if (opc == OPC_OPIMM) b = shamt;
                  if (f7 != F7_BASE) bad = 1'b1;
               end
               3'b101: begin
                  if (opc == OPC_OPIMM) b = shamt;
                  if (f7 == F7_BASE)     aluop = ALU_SRL;
                  else if (f7 == F7_ALT) aluop = ALU_SRA;
                  else                   bad   = 1'b1;
               end
               default: begin
                  case (f3)
                     3'b010:  aluop = ALU_SLT;
                     3'b011:  aluop = ALU_SLTU;
                     3'b100:  aluop = ALU_XOR;
                     3'b110:  aluop = ALU_OR;
                     default: aluop = ALU_AND;
                  endcase
                  if (opc == OPC_OP && f7 != F7_BASE) bad = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            b = imm_u;
         end
         OPC_AUIPC: begin
            a = pc;
            b = imm_u;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         a     = '0;
         b     = '0;
         aluop = ALU_ADD;
      end
   end

   assign illegal = bad;
   assign wb_en   = !bad && (rd != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: valid/ready handshake toward decode and a single-entry register toward the ALU.
// Flush beats accept; a held entry stays put while EX stalls.
module alu_issue
   import rv32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   input  logic             ex_stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [3:0]       out_aluop,
   output logic [4:0]       out_rd,
   output logic             out_wb_en,
   output logic             out_illegal
);

   logic [WIDTH-1:0] a_p0, b_p0;
   logic [3:0]       aluop_p0;
   logic [4:0]       rd_p0;
   logic             wb_en_p0, illegal_p0;
   logic             accept;

   logic             vld_p1;
   logic [WIDTH-1:0] a_p1, b_p1;
   logic [3:0]       aluop_p1;
   logic [4:0]       rd_p1;
   logic             wb_en_p1, illegal_p1;

   // p0: decode from the raw decode-stage inputs
   alu_decode #(.WIDTH(WIDTH)) u_decode (
      .instr   (instr),
      .pc      (pc),
      .rs1     (rs1_data),
      .rs2     (rs2_data),
      .a       (a_p0),
      .b       (b_p0),
      .aluop   (aluop_p0),
      .rd      (rd_p0),
      .wb_en   (wb_en_p0),
      .illegal (illegal_p0)
   );

   assign in_ready = !vld_p1 || !ex_stall;
   assign accept   = in_valid && in_ready;

   // p1: ID/EX register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         a_p1       <= '0;
         b_p1       <= '0;
         aluop_p1   <= ALU_ADD;
         rd_p1      <= '0;
         wb_en_p1   <= 1'b0;
         illegal_p1 <= 1'b0;
      end else if (flush) begin
         vld_p1   <= 1'b0;
         wb_en_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1     <= 1'b1;
         a_p1       <= a_p0;
         b_p1       <= b_p0;
         aluop_p1   <= aluop_p0;
         rd_p1      <= rd_p0;
         wb_en_p1   <= wb_en_p0;
         illegal_p1 <= illegal_p0;
      end else if (vld_p1 && !ex_stall) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid   = vld_p1;
   assign out_a       = a_p1;
   assign out_b       = b_p1;
   assign out_aluop   = aluop_p1;
   assign out_rd      = rd_p1;
   assign out_wb_en   = wb_en_p1;
   assign out_illegal = illegal_p1;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- ID/EX issue stage for the integer ALU: decodes RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into a 4-bit ALUOp.
- Selects and extends operands, then registers them into a single-entry ID/EX pipeline register.
- Supports a valid/ready handshake toward decode, stall from EX, and flush from branch resolution.
- Produces exactly the a/b/ALUOp triple the EX-stage ALU consumes.

Parameters:
- WIDTH, 32, datapath width (only 32 supported; immediates sign-extend to WIDTH).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  issue stage can accept this cycle
- instr  in  32  raw instruction word
- pc  in  WIDTH  PC of instr
- rs1_data  in  WIDTH  forwarded rs1 value
- rs2_data  in  WIDTH  forwarded rs2 value
- ex_stall  in  1  EX cannot consume the held entry
- flush  in  1  kill held entry and any entry being accepted
- out_valid  out  1  held entry is valid
- out_a  out  WIDTH  ALU operand a
- out_b  out  WIDTH  ALU operand b
- out_aluop  out  4  ALU operation code
- out_rd  out  5  destination register
- out_wb_en  out  1  write back result
- out_illegal  out  1  entry is not a supported ALU instruction

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_a=0, out_b=0, out_aluop=2, out_rd=0, out_wb_en=0, out_illegal=0. Takes effect immediately, mid-operation included; the held entry is discarded.
- ALUOp encoding: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- in_ready = !out_valid || !ex_stall (combinational). Accept = in_valid && in_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on the out_* ports after edge N.
- Each cycle, priority order:
  1. flush: out_valid<=0; other outputs don't-care, but wb_en<=0.
  2. accept: load decoded entry, out_valid<=1.
  3. out_valid && !ex_stall (no accept): out_valid<=0.
  4. Otherwise: hold all outputs.
- flush with simultaneous accept: the incoming instruction is dropped.
- ex_stall with out_valid=0: ignored; the stage accepts normally.
- Decode, by opcode:
  - OP (0110011): a=rs1, b=rs2. funct3 000→ADD (funct7 0000000) or SUB (0100000); 001→SLL; 010→SLT; 011→SLTU; 100→XOR; 101→SRL (0000000) or SRA (0100000); 110→OR; 111→AND. Any other funct7 is illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-imm. Same funct3 map with no SUB. For shifts, b={27'b0, instr[24:20]}; SLLI requires funct7=0000000; SRLI/SRAI use funct7 0000000/0100000. Other funct7 is illegal.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD.
  - AUIPC (0010111): a=pc, b=U-imm, ADD.
  - Any other opcode: illegal.
- Illegal entry: out_illegal=1, out_wb_en=0, out_aluop=2, a=b=0. It is still issued (out_valid=1) so the trap logic sees it.
- out_wb_en = legal && rd!=0.
- Operands are captured at accept. Later rs1_data/rs2_data changes do not affect the held entry.

Decomposition:
- Shared package (rv32_pkg): ALUOp localparams (ALU_AND..ALU_SLTU), opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC), funct7 constants (F7_BASE, F7_ALT).
- One combinational sub-module, alu_decode: instr, pc, rs1, rs2 → a, b, aluop, rd, wb_en, illegal.
- alu_issue itself holds only the handshake and pipeline register.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, in_valid=1 → next cycle out_valid=1, aluop=2, a=5, b=7, rd=3, wb_en=1.
- SUB 0x402081B3 → aluop=3. SRAI x5,x6,3 (0x40335293) → aluop=7, b=3, rd=5. ADDI x1,x0,-1 (0xFFF00093) with rs1=0 → aluop=2, b=0xFFFFFFFF.
- LUI x7,0x12345 (0x123453B7) → a=0, b=0x12345000, aluop=2. AUIPC with pc=0x100, imm=1 → a=0x100, b=0x1000.
- MUL encoding 0x022081B3 → out_illegal=1, wb_en=0, out_valid=1. ADD with rd=0 → wb_en=0, illegal=0.
- Hold out_valid=1, ex_stall=1 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Drop ex_stall → next entry loads the following cycle with no gap.
- Assert flush in the same cycle as an accept → out_valid=0 next cycle. Pulse rst_n low mid-stall → out_valid drops immediately without waiting for a clock edge.
